capture_sequencer: RTL and testbench

- Sequences writes from the OV7670 capture path into a double-banked frame buffer, in the camera pixel-clock domain.
- Gates capture until sensor configuration is finished and discards partial frames.
- Supports live, freeze and single-snapshot modes.
- Swaps write/display banks only on frame boundaries, so VGA scanout never shows a torn frame.

---
 rtl/capture_sequencer.sv | 177 +++++++++++++++++
 tb/tb_capture_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Pixel-clock write sequencer for a double-banked OV7670 frame buffer (live / freeze / snapshot).
// Define CAPTURE_SEQ_STATS_EN to add the frames_ok / frames_short counters.
module capture_sequencer #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned FRAME_WORDS = 76800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              config_done,
  input  logic              freeze,
  input  logic              snap_req,
  input  logic              vsync,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  output logic              fb_wea,
  output logic [ADDR_W:0]   fb_addra,
  output logic [DATA_W-1:0] fb_dina,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
`ifdef CAPTURE_SEQ_STATS_EN
  ,
  output logic [15:0]       frames_ok,
  output logic [15:0]       frames_short
`endif
);

  localparam int unsigned     CNT_W    = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_WORDS);
  localparam logic [ADDR_W:0]  ADDR_LIM = (ADDR_W + 1)'(FRAME_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    CAPTURE,
    HOLD,
    SNAP
  } state_t;

  state_t           state;
  logic             write_bank;
  logic             vsync_q;
  logic             armed;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] cnt_next;

  logic fstart;
  logic fend;
  logic writing;
  logic pass;
  logic in_range;
  logic accept;
  logic rejected;
  logic full;
  logic commit;

  assign fstart   = vsync_q & ~vsync;
  assign fend     = ~vsync_q & vsync;
  assign writing  = (state == CAPTURE) || (state == SNAP);
  assign pass     = writing & ~vsync;
  assign in_range = {1'b0, cap_addr} < ADDR_LIM;
  assign accept   = cap_we & pass & in_range;
  assign rejected = cap_we & pass & ~in_range;
  assign full     = (word_cnt == FULL_CNT);
  assign cnt_next = full ? word_cnt : word_cnt + 1'b1;
  // A falling config_done overrides a coincident frame end, so no commit then.
  assign commit   = config_done & fend & writing;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_wea   <= 1'b0;
      fb_addra <= '0;
      fb_dina  <= '0;
      overflow <= 1'b0;
      vsync_q  <= 1'b1;
    end else begin
      fb_wea   <= accept;
      fb_addra <= {write_bank, cap_addr};
      fb_dina  <= cap_data;
      vsync_q  <= vsync;
      if (rejected) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      write_bank <= 1'b1;
      disp_bank  <= 1'b0;
      word_cnt   <= '0;
      armed      <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        word_cnt <= cnt_next;
      end
      if (commit && full) begin
        disp_bank  <= write_bank;
        write_bank <= ~write_bank;
        frame_done <= 1'b1;
      end
      if (!config_done) begin
        state <= IDLE;
        armed <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SYNC;
          end
          SYNC: begin
            if (fstart) begin
              word_cnt <= '0;
              state    <= freeze ? HOLD : CAPTURE;
              busy     <= ~freeze;
            end
          end
          CAPTURE: begin
            // A write landing on the start cycle is the first word of the new frame.
            if (fstart) begin
              word_cnt <= accept ? CNT_W'(1) : '0;
            end else if (fend && freeze) begin
              state <= HOLD;
              busy  <= 1'b0;
            end
          end
          HOLD: begin
            if (!freeze) begin
              state <= SYNC;
              armed <= 1'b0;
            end else if (armed && fstart) begin
              state    <= SNAP;
              word_cnt <= '0;
              armed    <= 1'b0;
              busy     <= 1'b1;
            end else if (snap_req) begin
              armed <= 1'b1;
            end
          end
          SNAP: begin
            if (fend) begin
              state <= freeze ? HOLD : SYNC;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CAPTURE_SEQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frames_ok    <= '0;
      frames_short <= '0;
    end else if (commit) begin
      if (full) begin
        frames_ok <= frames_ok + 16'd1;
      end else begin
        frames_short <= frames_short + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized bench for capture_sequencer against a frame-level reference model (reduced frame size).
module tb_capture_sequencer;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned FW     = 96;
  localparam int unsigned BLANK  = 5;

  localparam int unsigned EV_NONE    = 0;
  localparam int unsigned EV_CFG_ON  = 1;
  localparam int unsigned EV_CFG_OFF = 2;
  localparam int unsigned EV_FREEZE  = 3;
  localparam int unsigned EV_RESET   = 4;

  logic              clk;
  logic              reset;
  logic              config_done;
  logic              freeze;
  logic              snap_req;
  logic              vsync;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              fb_wea;
  logic [ADDR_W:0]   fb_addra;
  logic [DATA_W-1:0] fb_dina;
  logic              disp_bank;
  logic              frame_done;
  logic              overflow;
  logic              busy;
`ifdef CAPTURE_SEQ_STATS_EN
  logic [15:0]       frames_ok;
  logic [15:0]       frames_short;
`endif

  capture_sequencer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FRAME_WORDS(FW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .config_done(config_done),
    .freeze     (freeze),
    .snap_req   (snap_req),
    .vsync      (vsync),
    .cap_we     (cap_we),
    .cap_addr   (cap_addr),
    .cap_data   (cap_data),
    .fb_wea     (fb_wea),
    .fb_addra   (fb_addra),
    .fb_dina    (fb_dina),
    .disp_bank  (disp_bank),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
`ifdef CAPTURE_SEQ_STATS_EN
    ,
    .frames_ok   (frames_ok),
    .frames_short(frames_short)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference: what each frame should do, decided at its start and end.
  typedef enum int {M_IDLE, M_SYNC, M_LIVE, M_HOLD, M_SNAP} mode_t;
  mode_t       m_mode;
  bit          m_armed;
  bit          m_wb;
  bit          m_disp;
  bit          m_ovf;
  int unsigned m_ok;
  int unsigned m_short;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return (m_mode == M_LIVE) || (m_mode == M_SNAP);
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_armed = 1'b0;
    m_wb    = 1'b1;
    m_disp  = 1'b0;
    m_ovf   = 1'b0;
    m_ok    = 0;
    m_short = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_fb_wea", fb_wea, 0);
    check("rst_fb_addra", 32'(fb_addra), 0);
    check("rst_fb_dina", 32'(fb_dina), 0);
    check("rst_disp_bank", disp_bank, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
`ifdef CAPTURE_SEQ_STATS_EN
    check("rst_frames_ok", 32'(frames_ok), 0);
    check("rst_frames_short", 32'(frames_short), 0);
`endif
  endtask

  // Drive one cycle of inputs, then check what the DUT registered from them.
  task automatic step(input logic vs, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input bit exp_we, input bit exp_fd);
    vsync    = vs;
    cap_we   = we;
    cap_addr = a;
    cap_data = d;
    @(posedge clk);
    #1;
    check("fb_wea", fb_wea, exp_we);
    if (exp_we) begin
      check("fb_addra", 32'(fb_addra), 32'({m_wb, a}));
      check("fb_dina", 32'(fb_dina), 32'(d));
    end
    check("frame_done", frame_done, exp_fd);
    cap_we = 1'b0;
  endtask

  task automatic idle(input logic vs);
    step(vs, 1'b0, ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
  endtask

  task automatic blank_rand();
    step(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
  endtask

  task automatic check_state();
    check("disp_bank", disp_bank, m_disp);
    check("overflow", overflow, m_ovf);
    check("busy_blank", busy, m_busy());
`ifdef CAPTURE_SEQ_STATS_EN
    check("frames_ok", 32'(frames_ok), m_ok % 65536);
    check("frames_short", 32'(frames_short), m_short % 65536);
`endif
  endtask

  task automatic run_frame(input int unsigned nwords, input int unsigned ev,
                           input int unsigned ev_at, input bit ovf_inj);
    bit          wr;
    bit          full;
    int unsigned cnt;
    cnt = 0;
    case (m_mode)
      M_SYNC: begin
        if (freeze) begin
          m_mode = M_HOLD;
          wr     = 1'b0;
        end else begin
          m_mode = M_LIVE;
          wr     = 1'b1;
        end
      end
      M_LIVE: wr = 1'b1;
      M_HOLD: begin
        if (m_armed) begin
          m_mode  = M_SNAP;
          m_armed = 1'b0;
          wr      = 1'b1;
        end else begin
          wr = 1'b0;
        end
      end
      default: wr = 1'b0;
    endcase
    idle(1'b0);
    idle(1'b0);
    check("busy_frame", busy, m_busy());
    for (int unsigned i = 0; i < nwords; i++) begin
      if (ev != EV_NONE && i == ev_at) begin
        case (ev)
          EV_CFG_ON: begin
            config_done = 1'b1;
            idle(1'b0);
            if (m_mode == M_IDLE) m_mode = M_SYNC;
          end
          EV_CFG_OFF: begin
            config_done = 1'b0;
            idle(1'b0);
            m_mode  = M_IDLE;
            m_armed = 1'b0;
            wr      = 1'b0;
          end
          EV_FREEZE: begin
            freeze = 1'b1;
            idle(1'b0);
          end
          default: begin
            #2 reset = 1'b1;
            #1;
            check_reset_outputs();
            @(posedge clk);
            #1;
            reset = 1'b0;
            model_reset();
            if (config_done) m_mode = M_SYNC;
            wr = 1'b0;
          end
        endcase
      end
      if (ovf_inj && i == nwords / 2) begin
        step(1'b0, 1'b1, ADDR_W'(FW), DATA_W'($urandom), 1'b0, 1'b0);
        step(1'b0, 1'b1, '1, DATA_W'($urandom), 1'b0, 1'b0);
        if (wr) m_ovf = 1'b1;
      end
      repeat ($urandom_range(0, 2)) idle(1'b0);
      step(1'b0, 1'b1, ADDR_W'(i % FW), DATA_W'($urandom), wr, 1'b0);
      if (wr) cnt++;
    end
    idle(1'b0);
    full = (cnt >= FW);
    // Frame end carries a write attempt that must be blocked.
    step(1'b1, 1'b1, ADDR_W'($urandom), DATA_W'($urandom), 1'b0, wr && full);
    if (wr) begin
      if (full) begin
        m_disp = m_wb;
        m_wb   = ~m_wb;
        m_ok++;
      end else begin
        m_short++;
      end
      if (m_mode == M_LIVE) m_mode = freeze ? M_HOLD : M_LIVE;
      else                  m_mode = freeze ? M_HOLD : M_SYNC;
    end
    for (int unsigned b = 0; b < BLANK; b++) blank_rand();
    check_state();
  endtask

  task automatic set_cfg(input logic v);
    config_done = v;
    idle(1'b1);
    if (!v) begin
      m_mode  = M_IDLE;
      m_armed = 1'b0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_SYNC;
    end
  endtask

  task automatic set_freeze(input logic v);
    freeze = v;
    idle(1'b1);
    if (!v && m_mode == M_HOLD) begin
      m_mode  = M_SYNC;
      m_armed = 1'b0;
    end
  endtask

  task automatic do_snap();
    snap_req = 1'b1;
    idle(1'b1);
    snap_req = 1'b0;
    if (m_mode == M_HOLD) m_armed = 1'b1;
  endtask

  task automatic snap_and_unfreeze();
    snap_req = 1'b1;
    freeze   = 1'b0;
    idle(1'b1);
    snap_req = 1'b0;
    if (m_mode == M_HOLD) begin
      m_mode  = M_SYNC;
      m_armed = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned r;
    reset       = 1'b1;
    config_done = 1'b0;
    freeze      = 1'b0;
    snap_req    = 1'b0;
    vsync       = 1'b1;
    cap_we      = 1'b0;
    cap_addr    = '0;
    cap_data    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    repeat (BLANK) idle(1'b1);

    // Configuration completes mid-frame: that frame is discarded.
    run_frame(FW, EV_CFG_ON, 20, 1'b0);
    // Live mode: banks alternate, including a saturating over-long frame.
    run_frame(FW, EV_NONE, 0, 1'b0);
    run_frame(FW, EV_NONE, 0, 1'b0);
    run_frame(FW + 10, EV_NONE, 0, 1'b0);
    // Short frame then a normal one.
    run_frame(FW - 8, EV_NONE, 0, 1'b0);
    run_frame(FW, EV_NONE, 0, 1'b0);
    // Freeze raised during a frame: it commits, then three held frames.
    run_frame(FW, EV_FREEZE, 30, 1'b0);
    run_frame(FW, EV_NONE, 0, 1'b1);
    run_frame(FW, EV_NONE, 0, 1'b0);
    run_frame(FW, EV_NONE, 0, 1'b0);
    // Snapshots: a full one, then a short one.
    do_snap();
    run_frame(FW, EV_NONE, 0, 1'b0);
    run_frame(FW, EV_NONE, 0, 1'b0);
    do_snap();
    run_frame(FW - 8, EV_NONE, 0, 1'b0);
    run_frame(FW, EV_NONE, 0, 1'b0);
    // snap_req coinciding with freeze fall leaves nothing armed.
    snap_and_unfreeze();
    set_freeze(1'b1);
    run_frame(FW, EV_NONE, 0, 1'b0);
    run_frame(FW, EV_NONE, 0, 1'b0);
    set_freeze(1'b0);
    run_frame(FW, EV_NONE, 0, 1'b0);
    // Out-of-range writes are dropped and not counted.
    run_frame(FW - 1, EV_NONE, 0, 1'b1);
    run_frame(FW, EV_NONE, 0, 1'b0);
    // Configuration lost mid-frame, then restored.
    run_frame(FW, EV_CFG_OFF, FW / 2, 1'b0);
    set_cfg(1'b1);
    run_frame(FW, EV_NONE, 0, 1'b0);
    // Asynchronous reset mid-frame.
    run_frame(FW, EV_RESET, 50, 1'b0);
    run_frame(FW, EV_NONE, 0, 1'b0);

    for (int k = 0; k < 14; k++) begin
      r = $urandom_range(0, 3);
      if (r == 1) set_freeze(1'b1);
      else if (r == 2) set_freeze(1'b0);
      else if (r == 3) do_snap();
      case ($urandom_range(0, 2))
        0:       n = FW;
        1:       n = $urandom_range(FW / 2, FW - 1);
        default: n = FW + $urandom_range(1, 10);
      endcase
      run_frame(n, EV_NONE, 0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
